// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding a UART transmitter.
// The host writes bytes into a circular buffer; a small drain FSM hands them
// one at a time to the transmitter through the send/parallel_datain handshake,
// pacing each start on a baud tick and waiting for tx_done between frames.
module uart_tx_fifo #(
    parameter int Data_length = 8,
    parameter int DEPTH       = 8
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [Data_length-1:0] wr_data,
    input  logic                   clr_ovf,
    input  logic                   baudratetx,
    input  logic                   tx_done,
    output logic                   send,
    output logic [Data_length-1:0] parallel_datain,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Storage and control state
    logic [Data_length-1:0] mem [DEPTH];

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   send_q, send_d;
    logic [Data_length-1:0] pdata_q, pdata_d;
    logic                   baud_q, done_q;

    logic                   baud_rise;
    logic                   done_rise;
    logic                   pop;
    logic                   wr_accept;

    // Rising-edge detection; a level held high on tx_done only counts once
    assign baud_rise = baudratetx & ~baud_q;
    assign done_rise = tx_done & ~done_q;

    // Flags decoded from the registered occupancy
    assign full            = (count_q == FULL_CNT);
    assign empty           = (count_q == '0);
    assign count           = count_q;
    assign overflow        = ovf_q;
    assign send            = send_q;
    assign parallel_datain = pdata_q;
    assign busy            = (state_q != IDLE);

    // Drain FSM: start a frame on a baud tick, hold send for one baud period,
    // then wait for the transmitter to report completion
    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        pdata_d = pdata_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && baud_rise) begin
                    pop     = 1'b1;
                    pdata_d = mem[rd_ptr_q];
                    send_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    send_d  = 1'b0;
                end
            end
            HOLD: begin
                if (baud_rise) begin
                    send_d  = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A coincident baud tick is deliberately not used to restart;
                // the next frame waits for a later tick seen in IDLE.
                if (done_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                send_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Write acceptance, pointer advance, occupancy and overflow tracking
    always_comb begin
        wr_accept = wr_en && ((count_q != FULL_CNT) || pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A dropped write takes priority over a clear in the same cycle
        if (wr_en && !wr_accept) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Control and output registers; reset aborts any frame in flight
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            send_q   <= 1'b0;
            pdata_q  <= '0;
            baud_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            send_q   <= send_d;
            pdata_q  <= pdata_d;
            baud_q   <= baudratetx;
            done_q   <= tx_done;
        end
    end

    // Buffer storage; contents are meaningless once the pointers are reset
    always_ff @(posedge clk1) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed phases with random data and
// random transmitter latency, compared against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int BAUD  = 16;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          clr_ovf;
    logic          baudratetx;
    logic          tx_done;
    logic          send;
    logic [DW-1:0] parallel_datain;
    logic          full;
    logic          empty;
    logic [$clog2(DEPTH):0] count;
    logic          overflow;
    logic          busy;

    uart_tx_fifo #(.Data_length(DW), .DEPTH(DEPTH)) dut (
        .clk1            (clk1),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .clr_ovf         (clr_ovf),
        .baudratetx      (baudratetx),
        .tx_done         (tx_done),
        .send            (send),
        .parallel_datain (parallel_datain),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .overflow        (overflow),
        .busy            (busy)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;
    string cur = "init";

    // Reference model: queued bytes, frame phase (0 idle, 1 send high, 2 awaiting done)
    logic [DW-1:0] mq[$];
    int            phase;
    logic          m_send;
    logic [DW-1:0] m_pd;
    logic          m_ovf;
    logic          prev_b;
    logic          prev_d;

    // Environment: baud generator and transmitter stand-in
    int            baud_cnt = 0;
    logic          baud_en  = 1'b1;
    logic          auto_done = 1'b1;
    int            done_timer;
    logic          done_drive;
    logic          obs_send_prev;
    logic [DW-1:0] rx_log[$];
    logic [DW-1:0] exp_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("send", 32'(send), 32'(m_send));
        chk("pdata", 32'(parallel_datain), 32'(m_pd));
        chk("count", 32'(count), mq.size());
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(phase != 0));
    endtask

    task automatic model_reset();
        mq.delete();
        phase         = 0;
        m_send        = 1'b0;
        m_pd          = '0;
        m_ovf         = 1'b0;
        prev_b        = 1'b0;
        prev_d        = 1'b0;
        done_timer    = 0;
        done_drive    = 1'b0;
        obs_send_prev = 1'b0;
    endtask

    // One clock: drive inputs, advance the model by the documented rules, compare
    task automatic tick(input logic we, input logic [DW-1:0] wd, input logic co);
        logic b;
        logic brise;
        logic drise;
        logic popm;
        logic acc;
        b          = baud_en && (baud_cnt == 0);
        wr_en      = we;
        wr_data    = wd;
        clr_ovf    = co;
        baudratetx = b;
        tx_done    = done_drive;
        @(posedge clk1);
        #1;
        baud_cnt = (baud_cnt + 1) % BAUD;
        brise = b && !prev_b;
        drise = done_drive && !prev_d;
        popm  = (phase == 0) && (mq.size() > 0) && brise;
        acc   = we && ((mq.size() < DEPTH) || popm);
        if (popm) begin
            m_pd   = mq.pop_front();
            m_send = 1'b1;
            phase  = 1;
        end else if (phase == 1 && brise) begin
            m_send = 1'b0;
            phase  = 2;
            if (auto_done) done_timer = int'($urandom_range(2, 25));
        end else if (phase == 2 && drise) begin
            phase = 0;
        end
        if (acc) mq.push_back(wd);
        if (we && !acc) m_ovf = 1'b1;
        else if (co) m_ovf = 1'b0;
        prev_b = b;
        prev_d = done_drive;
        if (auto_done) begin
            done_drive = 1'b0;
            if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) done_drive = 1'b1;
            end
        end
        if (send === 1'b1 && obs_send_prev !== 1'b1) rx_log.push_back(parallel_datain);
        obs_send_prev = send;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((mq.size() != 0 || phase != 0) && n < budget) begin
            tick(1'b0, '0, 1'b0);
            n++;
        end
        chk("drain_in_budget", 32'(mq.size() == 0 && phase == 0), 32'd1);
    endtask

    task automatic compare_logs(input string tag);
        int n;
        chk({tag, "_len"}, rx_log.size(), exp_log.size());
        n = (rx_log.size() < exp_log.size()) ? rx_log.size() : exp_log.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(rx_log[i]), 32'(exp_log[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] burst [8];
        logic [DW-1:0] v;
        int            n;
        burst = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

        // Power-on reset
        cur        = "reset_init";
        rst        = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        clr_ovf    = 1'b0;
        baudratetx = 1'b0;
        tx_done    = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk1);
        #3 rst = 1'b1;
        idle(20);

        // Reset asserted while a frame is in HOLD with three words still queued
        cur     = "reset_mid_hold";
        baud_en = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b1, DW'($urandom), 1'b0);
        baud_en = 1'b1;
        n = 0;
        while (phase != 1 && n < 40) begin
            tick(1'b0, '0, 1'b0);
            n++;
        end
        chk("reached_hold_with_3", 32'(phase == 1 && mq.size() == 3), 32'd1);
        #2;
        baudratetx = 1'b0;
        tx_done    = 1'b0;
        rst        = 1'b0;
        #1;
        model_reset();
        chk("async_send", 32'(send), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        @(posedge clk1);
        #1;
        check_all();
        #3 rst = 1'b1;
        rx_log.delete();
        idle(40);
        chk("no_send_after_reset", rx_log.size(), 32'd0);

        // Single word through an empty FIFO
        cur = "single";
        rx_log.delete();
        exp_log.delete();
        tick(1'b1, 8'h01, 1'b0);
        exp_log.push_back(8'h01);
        drain(300);
        compare_logs("single");

        // Back-to-back burst fills the FIFO, then drains in order
        cur = "burst";
        rx_log.delete();
        exp_log.delete();
        baud_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, burst[i], 1'b0);
            exp_log.push_back(burst[i]);
        end
        chk("full_after_8", 32'(full), 32'd1);
        baud_en = 1'b1;
        drain(3000);
        compare_logs("burst");
        chk("burst_empty", 32'(empty), 32'd1);
        chk("burst_count", 32'(count), 32'd0);

        // Overflow: drop, clear, set-wins, then write accepted alongside a pop
        cur = "overflow";
        rx_log.delete();
        exp_log.delete();
        baud_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = DW'($urandom);
            tick(1'b1, v, 1'b0);
            exp_log.push_back(v);
        end
        tick(1'b1, 8'hAA, 1'b0);
        chk("dropped_ovf", 32'(overflow), 32'd1);
        chk("dropped_count", 32'(count), 32'd8);
        tick(1'b0, '0, 1'b1);
        chk("cleared_ovf", 32'(overflow), 32'd0);
        tick(1'b1, 8'h55, 1'b1);
        chk("set_wins_ovf", 32'(overflow), 32'd1);
        tick(1'b0, '0, 1'b1);
        baud_en = 1'b1;
        n = 0;
        while (baud_cnt != 0 && n < BAUD) begin
            tick(1'b0, '0, 1'b0);
            n++;
        end
        tick(1'b1, 8'hAA, 1'b0);
        exp_log.push_back(8'hAA);
        chk("push_pop_full_count", 32'(count), 32'd8);
        chk("push_pop_full_ovf", 32'(overflow), 32'd0);
        drain(5000);
        compare_logs("overflow");

        // Pointer wrap: twenty words in rounds of five with random gaps
        cur = "wrap";
        rx_log.delete();
        exp_log.delete();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) begin
                v = DW'($urandom);
                tick(1'b1, v, 1'b0);
                exp_log.push_back(v);
                idle(int'($urandom_range(0, 3)));
            end
            drain(3000);
        end
        compare_logs("wrap");

        // tx_done held high for three baud periods, rising on a baud tick
        cur = "held_done";
        rx_log.delete();
        exp_log.delete();
        auto_done  = 1'b0;
        done_drive = 1'b0;
        tick(1'b1, 8'hC3, 1'b0);
        tick(1'b1, 8'h3C, 1'b0);
        exp_log.push_back(8'hC3);
        exp_log.push_back(8'h3C);
        n = 0;
        while (phase != 2 && n < 100) begin
            tick(1'b0, '0, 1'b0);
            n++;
        end
        n = 0;
        while (baud_cnt != 0 && n < BAUD) begin
            tick(1'b0, '0, 1'b0);
            n++;
        end
        done_drive = 1'b1;
        tick(1'b0, '0, 1'b0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("no_start_on_same_tick", 32'(send), 32'd0);
        idle(BAUD - 1);
        chk("no_early_send", 32'(send), 32'd0);
        tick(1'b0, '0, 1'b0);
        chk("send_on_next_baud", 32'(send), 32'd1);
        chk("second_word", 32'(parallel_datain), 32'h3C);
        idle(3 * BAUD - BAUD - 1);
        chk("one_frame_per_done", rx_log.size(), 32'd2);
        done_drive = 1'b0;
        n = 0;
        while (phase != 2 && n < 100) begin
            tick(1'b0, '0, 1'b0);
            n++;
        end
        tick(1'b0, '0, 1'b0);
        done_drive = 1'b1;
        tick(1'b0, '0, 1'b0);
        done_drive = 1'b0;
        drain(200);
        compare_logs("held_done");
        chk("final_busy", 32'(busy), 32'd0);
        auto_done = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side byte buffer sitting directly upstream of the UART transmitter.
- Accepts bytes from a host write port into a circular FIFO.
- Drains bytes one at a time into the transmitter using the transmitter's send/parallel_datain handshake, paced by baudratetx and completed by tx_done.
- Lets the host queue bursts without polling tx_done per byte.

Parameters:
- Data_length, 8: width of each buffered word and of parallel_datain.
- DEPTH, 8: number of FIFO entries; must be a power of two, minimum 2.

Ports:
- clk1  input  1  system/transmit clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately, independent of clk1.
- wr_en  input  1  host write strobe, one word per cycle when high.
- wr_data  input  Data_length  host write data.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- baudratetx  input  1  baud tick from the transmitter, synchronous to clk1.
- tx_done  input  1  frame-complete level/pulse from the transmitter.
- send  output  1  start request to the transmitter.
- parallel_datain  output  Data_length  word presented to the transmitter.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a write was dropped.
- busy  output  1  high whenever the drain FSM is not in IDLE.

Behaviour:
Reset (rst low):
- send=0, parallel_datain=0, count=0, full=0, empty=1, overflow=0, busy=0.
- Read/write pointers = 0; FSM = IDLE.
- Edge-detect registers cleared to 0.
- Reset asserted mid-frame aborts the drain; queued data is discarded. The transmitter sees send fall asynchronously.

Edge detection:
- baud_q and done_q register baudratetx and tx_done each cycle.
- baud_rise = baudratetx & ~baud_q.
- done_rise = tx_done & ~done_q.
- A tx_done held high across frames counts only once.

Write path:
- A write is accepted when wr_en=1 and either count<DEPTH or a pop occurs in the same cycle.
- An accepted write stores wr_data at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- wr_en=1 while full with no same-cycle pop: the word is dropped, pointers and count are unchanged, and overflow goes to 1 on the next edge.
- overflow clears only on clr_ovf=1. If clr_ovf and a dropped write coincide, set wins.

Drain FSM (states IDLE, HOLD, WAIT_DONE):
- IDLE: if empty=0 and baud_rise:
  - pop: parallel_datain <= mem[rd_ptr], rd_ptr increments modulo DEPTH;
  - send <= 1; go to HOLD.
  - Otherwise stay in IDLE with send=0.
- HOLD: send held at 1 and parallel_datain stable. On the next baud_rise: send <= 0, go to WAIT_DONE. send is therefore high for exactly one baud period.
- WAIT_DONE: parallel_datain held stable. On done_rise go to IDLE.
  - A baud_rise in the same cycle as done_rise does not start a new frame; the next start needs a later baud_rise seen in IDLE.
- A done_rise seen in IDLE or HOLD is ignored.
- parallel_datain keeps the last popped value until the next pop.

Count and flags:
- count changes by +1 (write only), -1 (pop only), or 0 (both or neither).
- full and empty are decoded combinationally from registered count.
- Simultaneous write and pop while full: accepted, count stays DEPTH.
- Simultaneous write and pop while count=1: accepted, count stays 1.
- Write while empty: a pop cannot occur in that cycle. The new word becomes poppable the cycle after.

Latency:
- Word written into an empty FIFO while IDLE: send rises on the first baud_rise that occurs at least one cycle after the write edge.
- Subsequent words: one frame per (tx_done rise + next baud_rise).

Test Plan:
1. Reset behaviour: assert rst low mid-HOLD with count=3 -> send=0, count=0, empty=1, busy=0 immediately. After release, no send until new writes arrive.
2. Single word: write 8'h01 into empty FIFO, baud tick every 16 cycles -> send=1 with parallel_datain=8'h01 on the first baud_rise. send=0 on the next baud_rise. busy falls after tx_done pulse.
3. Burst order: write 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF back-to-back -> full=1 after the 8th write. Transmitter-side model sees the same 8 values in order, one per tx_done. Ends with empty=1, count=0.
4. Overflow: fill to DEPTH, write 8'hAA with no pop -> dropped, overflow=1, count=8. Pulse clr_ovf -> overflow=0. Writing while full in the same cycle as a pop -> accepted, count stays 8, 8'hAA eventually emitted.
5. Pointer wrap: perform 20 write/drain cycles with count oscillating 0..5 -> data order preserved across wrap, no spurious full/empty.
6. Held tx_done: hold tx_done high for 3 baud periods after a frame -> exactly one return to IDLE, and next send only after the following baud_rise.
